mc_frame_arb: RTL and testbench

MC_FRAME_ARB -- requirements
Module: mc_frame_arb

---
 rtl/mc_frame_arb.sv | 118 +++++++++++
 tb/tb_mc_frame_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_frame_arb.sv
`default_nettype none
// ============================================================================
// Module   : mc_frame_arb
// Purpose  : Burst-locked round-robin arbiter merging write and read frames
//            into a single registered stream towards the memory controller.
// Revision : 1.0
// ============================================================================
module mc_frame_arb #(
    parameter int FRAME_WIDTH = 97
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi2arb_wframe_valid,
    output logic                   axi2arb_wframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_wframe_data,
    input  logic                   axi2arb_rframe_valid,
    output logic                   axi2arb_rframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_rframe_data,
    output logic                   arb2mc_frame_valid,
    input  logic                   arb2mc_frame_ready,
    output logic [FRAME_WIDTH-1:0] arb2mc_frame_data,
    output logic                   arb2mc_frame_type
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic       TYPE_WR = 1'b0;
    localparam logic       TYPE_RD = 1'b1;

    logic [1:0]             state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic                   out_valid_q, out_valid_d;
    logic [FRAME_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_type_q, out_type_d;

    logic                   out_free;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   accept;
    logic                   acc_last;
    logic [FRAME_WIDTH-1:0] acc_data;

    // State and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= TYPE_RD;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_type_q  <= TYPE_WR;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_type_q  <= out_type_d;
        end
    end

    // Readies come only from registered state and the downstream ready
    always_comb begin
        out_free             = !out_valid_q || arb2mc_frame_ready;
        axi2arb_wframe_ready = !rst && (state_q == ST_WR) && out_free;
        axi2arb_rframe_ready = !rst && (state_q == ST_RD) && out_free;
        arb2mc_frame_valid   = out_valid_q;
        arb2mc_frame_data    = out_data_q;
        arb2mc_frame_type    = out_type_q;
    end

    always_comb begin
        wr_accept = axi2arb_wframe_valid && axi2arb_wframe_ready;
        rd_accept = axi2arb_rframe_valid && axi2arb_rframe_ready;
        accept    = wr_accept || rd_accept;
        acc_data  = rd_accept ? axi2arb_rframe_data : axi2arb_wframe_data;
        acc_last  = accept && acc_data[FRAME_WIDTH-1];
    end

    // Next-state: arbitrate from IDLE or on the last frame of a burst
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        if (acc_last) begin
            rr_last_d = rd_accept ? TYPE_RD : TYPE_WR;
        end
        case (state_q)
            ST_IDLE, ST_WR, ST_RD: begin
                if ((state_q == ST_IDLE) || acc_last) begin
                    if (axi2arb_wframe_valid && axi2arb_rframe_valid) begin
                        state_d = (rr_last_d == TYPE_RD) ? ST_WR : ST_RD;
                    end else if (axi2arb_wframe_valid) begin
                        state_d = ST_WR;
                    end else if (axi2arb_rframe_valid) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_type_d  = out_type_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data;
            out_type_d  = rd_accept ? TYPE_RD : TYPE_WR;
        end else if (arb2mc_frame_ready) begin
            out_valid_d = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_frame_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_frame_arb
// Purpose  : Self-checking bench for mc_frame_arb with a queue-based model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mc_frame_arb;

    localparam int FW = 97;
    typedef logic [FW-1:0] frame_t;
    typedef logic [FW:0]   rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wv = 1'b0, rv = 1'b0, mc_rdy = 1'b0;
    logic         wrdy, rrdy, ov, otype;
    logic [FW-1:0] wd = '0, rd = '0, od;

    always #5 clk = ~clk;

    mc_frame_arb #(.FRAME_WIDTH(FW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .axi2arb_wframe_valid (wv),
        .axi2arb_wframe_ready (wrdy),
        .axi2arb_wframe_data  (wd),
        .axi2arb_rframe_valid (rv),
        .axi2arb_rframe_ready (rrdy),
        .axi2arb_rframe_data  (rd),
        .arb2mc_frame_valid   (ov),
        .arb2mc_frame_ready   (mc_rdy),
        .arb2mc_frame_data    (od),
        .arb2mc_frame_type    (otype)
    );

    frame_t wq[$], rq[$];
    rec_t   obs[$], exp_q[$];
    int     obs_cyc[$];
    bit     rdy_pat[$];
    int     checks = 0, failures = 0;
    int     cyc = 0, ready_err = 0, out_err = 0;
    int     w_pct = 100, r_pct = 100, rdy_pct = 100, w_gap = 0;
    bit     rst_req = 1'b1, w_hold = 1'b0, r_hold = 1'b0;

    // Model: who owns the grant (0 none, 1 write, 2 read), last burst type,
    // and the frame sitting in the one-deep output stage.
    int     m_grant = 0;
    bit     m_rr_read = 1'b1;
    bit     m_occ = 1'b0;
    rec_t   m_out = '0;

    function automatic frame_t mk_frame(bit last);
        frame_t f;
        f[FW-2:0] = {$urandom(), $urandom(), $urandom()};
        f[FW-1]   = last;
        return f;
    endfunction

    task automatic push_burst(bit is_rd, int len);
        for (int i = 0; i < len; i++) begin
            if (is_rd) rq.push_back(mk_frame(i == len - 1));
            else       wq.push_back(mk_frame(i == len - 1));
        end
    endtask

    task automatic tick();
        bit   m_wr, m_rd, w_acc, r_acc, free, last_acc;
        rec_t acc_rec;
        @(negedge clk);
        rst = rst_req;
        wv  = (wq.size() > 0) && (w_hold || (w_gap == 0 && $urandom_range(99) < w_pct));
        rv  = (rq.size() > 0) && (r_hold || $urandom_range(99) < r_pct);
        wd  = '0;
        rd  = '0;
        if (wv) wd = wq[0];
        if (rv) rd = rq[0];
        if (rdy_pat.size() > 0) mc_rdy = rdy_pat.pop_front();
        else                    mc_rdy = ($urandom_range(99) < rdy_pct);
        #1;
        free = !m_occ || mc_rdy;
        m_wr = !rst && (m_grant == 1) && free;
        m_rd = !rst && (m_grant == 2) && free;
        if (wrdy !== m_wr || rrdy !== m_rd) ready_err++;
        if (ov !== m_occ) out_err++;
        else if (m_occ && ({otype, od} !== m_out)) out_err++;
        if (ov && mc_rdy) begin
            obs.push_back({otype, od});
            obs_cyc.push_back(cyc);
        end
        w_acc  = wv && m_wr;
        r_acc  = rv && m_rd;
        w_hold = wv && !w_acc;
        r_hold = rv && !r_acc;
        if (w_acc) void'(wq.pop_front());
        if (r_acc) void'(rq.pop_front());
        if (rst) begin
            m_grant = 0; m_rr_read = 1'b1; m_occ = 1'b0; m_out = '0;
            w_hold = 1'b0; r_hold = 1'b0;
        end else begin
            if (m_occ && mc_rdy) m_occ = 1'b0;
            last_acc = 1'b0;
            acc_rec  = '0;
            if (w_acc || r_acc) begin
                acc_rec  = w_acc ? {1'b0, wd} : {1'b1, rd};
                m_occ    = 1'b1;
                m_out    = acc_rec;
                exp_q.push_back(acc_rec);
                last_acc = acc_rec[FW-1];
            end
            if (last_acc) m_rr_read = acc_rec[FW];
            if (m_grant == 0 || last_acc)
                m_grant = (wv && rv) ? (m_rr_read ? 1 : 2) : (wv ? 1 : (rv ? 2 : 0));
        end
        if (w_gap > 0) w_gap--;
        cyc++;
    endtask

    task automatic do_reset(int n);
        wq.delete(); rq.delete(); rdy_pat.delete();
        w_gap = 0; w_pct = 100; r_pct = 100; rdy_pct = 100;
        rst_req = 1'b1;
        repeat (n) tick();
        rst_req = 1'b0;
        obs.delete(); obs_cyc.delete(); exp_q.delete();
        ready_err = 0; out_err = 0;
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        push_burst(0, 2);
        push_burst(1, 2);
        repeat (3) tick();
        checks++; if (wrdy !== 1'b0 || rrdy !== 1'b0) begin failures++;
            $display("FAIL reset_ready: got w=%0b r=%0b required 0 0", wrdy, rrdy); end
        checks++; if (ov !== 1'b0 || otype !== 1'b0) begin failures++;
            $display("FAIL reset_valid_type: got v=%0b t=%0b required 0 0", ov, otype); end
        checks++; if (od !== '0) begin failures++;
            $display("FAIL reset_data: got %h required 0", od); end
        rst_req = 1'b0;
        tick();
        checks++; if (wrdy !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset: wready got %0b required 0", wrdy); end
        tick();
        checks++; if (wrdy !== 1'b1 || rrdy !== 1'b0) begin failures++;
            $display("FAIL first_grant: got w=%0b r=%0b required 1 0", wrdy, rrdy); end
    endtask

    task automatic test_write_only();
        frame_t sent[$];
        do_reset(2);
        push_burst(0, 4);
        sent = wq;
        for (int i = 0; i < 20 && obs.size() < 4; i++) tick();
        checks++; if (obs.size() != 4) begin failures++;
            $display("FAIL wr_only_count: got %0d required 4", obs.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs[i] !== {1'b0, sent[i]}) begin failures++;
                    $display("FAIL wr_only_frame%0d: got %h required %h", i, obs[i], {1'b0, sent[i]}); end
            end
            checks++; if (obs_cyc[3] - obs_cyc[0] != 3) begin failures++;
                $display("FAIL wr_only_span: got %0d required 3", obs_cyc[3] - obs_cyc[0]); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL wr_only_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_tie();
        frame_t ws[$], rs[$];
        rec_t   e;
        do_reset(2);
        push_burst(0, 3);
        push_burst(1, 3);
        ws = wq; rs = rq;
        for (int i = 0; i < 30 && obs.size() < 6; i++) tick();
        checks++; if (obs.size() != 6) begin failures++;
            $display("FAIL tie_count: got %0d required 6", obs.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                e = (i < 3) ? {1'b0, ws[i]} : {1'b1, rs[i-3]};
                checks++; if (obs[i] !== e) begin failures++;
                    $display("FAIL tie_frame%0d: got %h required %h", i, obs[i], e); end
            end
            checks++; if (obs_cyc[5] - obs_cyc[0] != 5) begin failures++;
                $display("FAIL tie_bubble: span got %0d required 5", obs_cyc[5] - obs_cyc[0]); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL tie_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_fairness();
        int bad = 0;
        bit e;
        do_reset(2);
        for (int b = 0; b < 8; b++) begin push_burst(0, 2); push_burst(1, 2); end
        for (int i = 0; i < 60 && obs.size() < 16; i++) tick();
        checks++; if (obs.size() < 16) begin failures++;
            $display("FAIL fair_count: got %0d required 16", obs.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                e = ((i / 2) % 2) == 1;
                if (obs[i][FW] !== e) bad++;
            end
            checks++; if (bad != 0) begin failures++;
                $display("FAIL fair_types: got %0d wrong types required 0", bad); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL fair_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_backpressure();
        frame_t sent[$];
        do_reset(2);
        push_burst(0, 5);
        sent = wq;
        for (int k = 0; k < 4; k++) begin
            rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
            rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        end
        for (int i = 0; i < 40 && obs.size() < 5; i++) tick();
        repeat (3) tick();
        checks++; if (obs.size() != 5) begin failures++;
            $display("FAIL bp_count: got %0d required 5", obs.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (obs[i] !== {1'b0, sent[i]}) begin failures++;
                    $display("FAIL bp_frame%0d: got %h required %h", i, obs[i], {1'b0, sent[i]}); end
            end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL bp_stable: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        push_burst(1, 4);
        for (int i = 0; i < 20 && rq.size() > 2; i++) tick();
        wq.delete(); rq.delete();
        push_burst(0, 2);
        push_burst(1, 2);
        rst_req = 1'b1;
        tick();
        checks++; if (wrdy !== 1'b0 || rrdy !== 1'b0) begin failures++;
            $display("FAIL midrst_ready1: got w=%0b r=%0b required 0 0", wrdy, rrdy); end
        tick();
        checks++; if (wrdy !== 1'b0 || rrdy !== 1'b0 || ov !== 1'b0) begin failures++;
            $display("FAIL midrst_ready2: got w=%0b r=%0b v=%0b required 0 0 0", wrdy, rrdy, ov); end
        rst_req = 1'b0;
        obs.delete(); obs_cyc.delete(); exp_q.delete();
        ready_err = 0; out_err = 0;
        for (int i = 0; i < 30 && obs.size() < 4; i++) tick();
        checks++; if (obs.size() != 4) begin failures++;
            $display("FAIL midrst_count: got %0d required 4", obs.size()); end
        else begin
            checks++; if ({obs[0][FW], obs[1][FW], obs[2][FW], obs[3][FW]} !== 4'b0011) begin failures++;
                $display("FAIL midrst_order: got %b required 0011",
                         {obs[0][FW], obs[1][FW], obs[2][FW], obs[3][FW]}); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL midrst_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_gap();
        int rd_seen = 0;
        do_reset(2);
        push_burst(0, 4);
        push_burst(1, 2);
        for (int i = 0; i < 20 && wq.size() > 2; i++) tick();
        w_gap = 3;
        for (int i = 0; i < 40 && wq.size() > 0; i++) begin
            tick();
            if (rrdy !== 1'b0) rd_seen++;
        end
        checks++; if (rd_seen != 0 || wq.size() != 0) begin failures++;
            $display("FAIL gap_rready: got %0d rready cycles, %0d left required 0 0", rd_seen, wq.size()); end
        for (int i = 0; i < 30 && obs.size() < 6; i++) tick();
        checks++; if (obs.size() != 6) begin failures++;
            $display("FAIL gap_count: got %0d required 6", obs.size()); end
        else begin
            checks++; if ({obs[3][FW], obs[4][FW], obs[5][FW]} !== 3'b011) begin failures++;
                $display("FAIL gap_order: got %b required 011", {obs[3][FW], obs[4][FW], obs[5][FW]}); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL gap_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset(2);
        for (int ph = 0; ph < 4; ph++) begin
            w_pct   = $urandom_range(100, 30);
            r_pct   = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 30);
            for (int i = 0; i < 500; i++) begin
                if (wq.size() < 2) push_burst(0, $urandom_range(4, 1));
                if (rq.size() < 2) push_burst(1, $urandom_range(4, 1));
                tick();
            end
        end
        checks++; if (obs.size() < 100 || obs.size() > exp_q.size()) begin failures++;
            $display("FAIL rand_count: got %0d outputs, %0d accepted", obs.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < obs.size(); i++) if (obs[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin failures++;
                $display("FAIL rand_order: got %0d mismatched frames required 0", bad); end
        end
        checks++; if (ready_err != 0 || out_err != 0) begin failures++;
            $display("FAIL rand_model: got ready_err=%0d out_err=%0d required 0", ready_err, out_err); end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_tie();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
